// File: rtl/image_pkg.sv
// Shared geometry and register map for the HPS image capture/playback paths.
// Field is a 224x224 square anchored at (208,128) in 640x480 scan space.
package image_pkg;

  localparam int IMG_W      = 224;
  localparam int IMG_PIXELS = IMG_W * IMG_W;
  localparam int IMG_WORDS  = IMG_PIXELS / 4;
  localparam int WORD_AW    = 14;

  localparam int BOX_X0 = 208;
  localparam int BOX_Y0 = 128;
  localparam int BOX_X1 = BOX_X0 + IMG_W - 1;
  localparam int BOX_Y1 = BOX_Y0 + IMG_W - 1;

  typedef enum logic [1:0] {
    REG_PIXEL       = 2'd0,
    REG_WR_PTR      = 2'd1,
    REG_CTRL        = 2'd2,
    REG_FRAME_COUNT = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/image_writer_ram.sv
// Two-bank frame store: 32-bit write port, registered 32-bit read port.
// Bank bit is the outer (MSB) index so each bank is a contiguous block.
module image_writer_ram #(
  parameter int WORDS = 12544,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          rbank_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2][WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wbank_i][waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[rbank_i][raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/image_writer.sv
// HPS-loaded 224x224 overlay: Avalon register window into a double-buffered
// frame store, replayed against scan coordinates with 2-cycle latency.
module image_writer
  import image_pkg::*;
#(
  parameter int IMG_W  = image_pkg::IMG_W,
  parameter int BOX_X0 = image_pkg::BOX_X0,
  parameter int BOX_Y0 = image_pkg::BOX_Y0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scan_valid,
  input  logic [10:0] scan_x,
  input  logic [10:0] scan_y,
  output logic        ovl_valid,
  output logic        ovl_in_box,
  output logic [7:0]  ovl_pixel
);

  localparam int PIXELS = IMG_W * IMG_W;
  localparam int WORDS  = PIXELS / 4;
  localparam int X1     = BOX_X0 + IMG_W - 1;
  localparam int Y1     = BOX_Y0 + IMG_W - 1;

  reg_addr_e reg_a;
  assign reg_a = reg_addr_e'(addr);

  logic [15:0] wr_ptr_q, wr_ptr_d;
  logic        enable_q, enable_d;
  logic        pending_q, pending_d;
  logic        front_q, front_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic        pix_we;
  logic        frame_start;

  logic [WORD_AW-1:0] s1_word_q;
  logic [1:0]         s1_sel_q;
  logic               s1_bank_q;
  logic               s1_hit_q;
  logic               s1_valid_q;
  logic [1:0]         s2_sel_q;
  logic               s2_hit_q;
  logic               s2_valid_q;

  logic        in_box;
  logic [10:0] dx, dy;
  logic [15:0] idx;
  logic [31:0] rdata;

  assign frame_start = scan_valid && scan_x == '0 && scan_y == '0;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    enable_d  = enable_q;
    pending_d = pending_q;
    front_d   = front_q;
    fcnt_d    = fcnt_q;
    pix_we    = 1'b0;
    if (wr_en) begin
      unique case (1'b1)
        reg_a == REG_PIXEL: begin
          pix_we   = 1'b1;
          wr_ptr_d = (wr_ptr_q == 16'(PIXELS - 4))
                   ? 16'd0 : wr_ptr_q + 16'd4;
        end
        reg_a == REG_WR_PTR: begin
          if (writedata < 32'(PIXELS))
            wr_ptr_d = {writedata[15:2], 2'b00};
        end
        reg_a == REG_CTRL: begin
          enable_d = writedata[1];
          if (writedata[0]) pending_d = 1'b1;
        end
        reg_a == REG_FRAME_COUNT: ;
      endcase
    end
    // a swap consumes the pending commit, even one re-written this cycle
    if (frame_start) begin
      fcnt_d = fcnt_q + 32'd1;
      if (pending_q) begin
        front_d   = ~front_q;
        pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (rd_en) begin
      unique case (1'b1)
        reg_a == REG_PIXEL:       readdata = '0;
        reg_a == REG_WR_PTR:      readdata = {16'd0, wr_ptr_q};
        reg_a == REG_CTRL:
          readdata = {29'd0, pending_q, enable_q, front_q};
        reg_a == REG_FRAME_COUNT: readdata = fcnt_q;
      endcase
    end
  end

  assign in_box = scan_valid
               && scan_x >= 11'(BOX_X0) && scan_x <= 11'(X1)
               && scan_y >= 11'(BOX_Y0) && scan_y <= 11'(Y1);

  always_comb begin
    dx  = '0;
    dy  = '0;
    idx = '0;
    if (in_box) begin
      dx  = scan_x - 11'(BOX_X0);
      dy  = scan_y - 11'(BOX_Y0);
      idx = 16'(dy) * 16'(IMG_W) + 16'(dx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      enable_q   <= 1'b0;
      pending_q  <= 1'b0;
      front_q    <= 1'b0;
      fcnt_q     <= '0;
      s1_word_q  <= '0;
      s1_sel_q   <= '0;
      s1_bank_q  <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_sel_q   <= '0;
      s2_hit_q   <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      front_q    <= front_d;
      fcnt_q     <= fcnt_d;
      s1_word_q  <= idx[15:2];
      s1_sel_q   <= idx[1:0];
      s1_bank_q  <= front_d;
      s1_hit_q   <= in_box && enable_q;
      s1_valid_q <= scan_valid;
      s2_sel_q   <= s1_sel_q;
      s2_hit_q   <= s1_hit_q;
      s2_valid_q <= s1_valid_q;
    end
  end

  image_writer_ram #(
    .WORDS(WORDS),
    .AW   (WORD_AW)
  ) u_ram (
    .clk    (clk),
    .we_i   (pix_we && !reset),
    .wbank_i(~front_q),
    .waddr_i(wr_ptr_q[15:2]),
    .wdata_i(writedata),
    .rbank_i(s1_bank_q),
    .raddr_i(s1_word_q),
    .rdata_o(rdata)
  );

  assign ovl_valid  = s2_valid_q;
  assign ovl_in_box = s2_hit_q;

  always_comb begin
    ovl_pixel = '0;
    if (s2_hit_q) begin
      unique case (s2_sel_q)
        2'd0: ovl_pixel = rdata[7:0];
        2'd1: ovl_pixel = rdata[15:8];
        2'd2: ovl_pixel = rdata[23:16];
        2'd3: ovl_pixel = rdata[31:24];
      endcase
    end
  end

endmodule

// File: doc/image_writer.md
# image_writer

Avalon-MM slave that lets the HPS load a 224x224 8-bit grayscale image into a double-buffered on-chip frame store. It replays that image as an overlay pixel stream aligned to the 640x480 scan coordinates. It is the write/playback counterpart of the capture path: same capture field (top-left (208,128), bottom-right (431,351)) and same register-window style, with data flowing HPS -> fabric -> display.

## Interface
Parameters:
- IMG_W, 224, image width and height in pixels
- BOX_X0, 208, left column of the field on screen
- BOX_Y0, 128, top row of the field on screen

Ports:
- clk  in  1  system clock (100 MHz); scan inputs already synchronized to it
- reset  in  1  synchronous, active-high reset
- addr  in  2  Avalon register address
- rd_en  in  1  Avalon read strobe
- wr_en  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data; combinational, 0 when rd_en=0
- scan_valid  in  1  scan_x/scan_y valid this cycle
- scan_x  in  11  current scan column
- scan_y  in  11  current scan row
- ovl_valid  out  1  scan_valid delayed 2 cycles
- ovl_in_box  out  1  delayed pixel lies inside the field and overlay is enabled
- ovl_pixel  out  8  overlay pixel; 0 when ovl_in_box=0

## Operation
- Register map, with writes taking effect on the clock edge where wr_en=1:
  - addr 0 PIXEL_DATA, write only: 4 pixels, byte0 = pixel wr_ptr and byte3 = wr_ptr+3. Written to the back bank. Then wr_ptr += 4, wrapping 50172 -> 0. Reads return 0.
  - addr 1 WR_PTR: a write sets wr_ptr = writedata & ~3 if writedata < 50176; otherwise the write is ignored. A read returns wr_ptr.
  - addr 2 CTRL: a write with bit1 sets enable := bit1. A write with bit0=1 sets commit_pending := 1. A read returns {29'b0, commit_pending, enable, front_bank}.
  - addr 3 FRAME_COUNT: read only, 32-bit count of frame starts, wrapping. Writes are ignored.
- Banks:
  - front_bank selects the bank used for playback. The back bank is !front_bank.
  - The HPS never writes the front bank.
- Frame start is any cycle with scan_valid && scan_x==0 && scan_y==0.
- At frame start:
  - frame_count increments.
  - If commit_pending=1, then front_bank toggles and commit_pending clears.
  - A CTRL commit write in the same cycle as frame start leaves pending=1 and swaps at the next frame start.
  - A commit written while already pending has no additional effect.
- Playback lookup:
  - in_box = scan_valid && 208<=x<=431 && 128<=y<=351.
  - idx = 224*(y-128) + (x-208), 16 bits. Word address = idx[15:2]; byte select = idx[1:0].
  - The bank used is the front_bank value after any swap in that cycle.
- Arithmetic: the subtractions are evaluated only when in_box=1, so no negative intermediates are used. idx max is 50175.

## Timing
- Reset values: front_bank=0, commit_pending=0, enable=0, wr_ptr=0, frame_count=0, ovl_valid=0, ovl_in_box=0, ovl_pixel=0. RAM contents are not reset.
- Playback latency is 2 cycles. Scan sample at cycle N produces ovl_* at N+2.
  - Stage 1 registers the word address, byte select and in_box&&enable.
  - Stage 2 is the registered RAM read, then the byte mux and output register.
- A PIXEL_DATA write at cycle N is visible to playback only after a commit swap. Back-bank data is never read by playback.
- Reset asserted mid-frame: outputs go to reset values on the next edge, and the pipeline is flushed. Any pending commit is lost.
- Simultaneous rd_en and wr_en to the same register: readdata shows the pre-write value.
- No wait states on writes; the Avalon side is always ready.

## Structure
- Package image_pkg holds IMG_W, IMG_PIXELS=50176, BOX_X0/Y0/X1/Y1 and an enum of register addresses. Shared with the capture path.
- Sub-module image_writer_ram:
  - Simple dual-port memory: 32-bit write port and 32-bit registered read port.
  - Depth 2x12544 words, with the bank bit as the address MSB.
  - Infers M10K.

## Test plan
- Reset, then read addr 2 and addr 3 -> 0 and 0; ovl_valid=0; wr_ptr reads 0.
- Write WR_PTR=50172, write PIXEL_DATA=0x44332211 -> WR_PTR reads 0. After commit + frame start and enable=1, scan (431,351) yields ovl_pixel=0x44 at +2 cycles.
- Fill the back bank with byte = idx[7:0], commit, enable. Scan (208,128)..(215,128) -> ovl_pixel 0x00..0x07 with 2-cycle latency. Scan (207,128) -> ovl_in_box=0, ovl_pixel=0.
- Write commit mid-frame -> CTRL reads pending=1 and bank=0 until frame start; the next cycle reads pending=0 and bank=1. FRAME_COUNT is +1.
- Commit write coincident with frame start -> bank unchanged and pending=1; the swap occurs at the following frame start.
- Write WR_PTR=50176 -> ignored, value unchanged. Assert reset mid-scan -> ovl_* = 0 next cycle, enable=0.
